// File: rtl/fifo_flow_ctrl_pkg.sv
// Shared constants, width helper and error-cause encoding for the flow-controlled FIFO.
// Error-cause bits are also consumed by the debug status register.
package fifo_flow_ctrl_pkg;

  localparam int DEFAULT_DATA_WIDTH = 6;
  localparam int DEFAULT_ADDR_WIDTH = 2;

  localparam int ERR_CAUSE_WIDTH = 2;
  localparam logic [ERR_CAUSE_WIDTH-1:0] ERR_NONE      = 2'b00;
  localparam logic [ERR_CAUSE_WIDTH-1:0] ERR_OVERFLOW  = 2'b01;
  localparam logic [ERR_CAUSE_WIDTH-1:0] ERR_UNDERFLOW = 2'b10;

  // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_flow_mem.sv
// DEPTH x DATA_WIDTH register array, one write port and one registered read port (1-cycle latency).
// No backpressure of its own: the caller gates wr_en/rd_en; rd_dat holds when rd_en is low.
module fifo_flow_mem #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_dat
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_dat_d;
  logic [DATA_WIDTH-1:0] rd_dat_q;

  // Storage is deliberately left unreset; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  always_comb begin
    rd_dat_d = rd_dat_q;
    if (rd_en) begin
      rd_dat_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rd_dat_q <= '0;
    end else begin
      rd_dat_q <= rd_dat_d;
    end
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/fifo_flow_ctrl.sv
// Synchronous FIFO with programmable thresholds, hysteretic pause and sticky error; pop data 1 cycle after pop.
// Upstream is throttled by pause; pushes to a full FIFO without a pop and pops from empty are dropped and flagged.
module fifo_flow_ctrl
  import fifo_flow_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int CNT_WIDTH  = cnt_width(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  input  logic [CNT_WIDTH-1:0]  afull_thr,
  input  logic [CNT_WIDTH-1:0]  aempty_thr,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  pause,
  output logic                  error
);

  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(1 << ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  data_valid_q, data_valid_d;
  logic                  pause_q, pause_d;
  logic                  error_q, error_d;

  logic                       push_ok;
  logic                       pop_ok;
  logic [ERR_CAUSE_WIDTH-1:0] err_cause;

  // Flags decode the registered occupancy only, never the live push/pop.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_CNT);
  assign almost_full  = (count_q >= afull_thr);
  assign almost_empty = (count_q <= aempty_thr) && (count_q != '0);

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  always_comb begin
    err_cause = ERR_NONE;
    if (push && full && !pop) begin
      err_cause = err_cause | ERR_OVERFLOW;
    end
    if (pop && empty) begin
      err_cause = err_cause | ERR_UNDERFLOW;
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_valid_d = pop_ok;
    pause_d      = pause_q;
    error_d      = error_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end

    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_WIDTH'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_WIDTH'(1);
    end

    // Set has priority so overlapping thresholds fail safe towards pausing.
    if (count_d >= afull_thr) begin
      pause_d = 1'b1;
    end else if (count_d <= aempty_thr) begin
      pause_d = 1'b0;
    end

    if (err_cause != ERR_NONE) begin
      error_d = 1'b1;
    end else if (err_clr) begin
      error_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_valid_q <= 1'b0;
      pause_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_valid_q <= data_valid_d;
      pause_q      <= pause_d;
      error_q      <= error_d;
    end
  end

  fifo_flow_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset_L (reset_L),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr_q),
    .wr_dat  (data_in),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr_q),
    .rd_dat  (data_out)
  );

  assign count      = count_q;
  assign data_valid = data_valid_q;
  assign pause      = pause_q;
  assign error      = error_q;

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Directed bench: stimulus queues expected pop data, a negedge monitor checks each data_valid word.
module tb_fifo_flow_ctrl;

  localparam int DW = 6;
  localparam int AW = 2;
  localparam int CW = 3;

  logic          clk;
  logic          reset_L;
  logic          push;
  logic [DW-1:0] data_in;
  logic          pop;
  logic [CW-1:0] afull_thr;
  logic [CW-1:0] aempty_thr;
  logic          err_clr;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          almost_empty;
  logic          pause;
  logic          error;

  int n_vec;
  int n_err;
  int exp_q[$];

  fifo_flow_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .afull_thr    (afull_thr),
    .aempty_thr   (aempty_thr),
    .err_clr      (err_clr),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .pause        (pause),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every word presented with data_valid must be the oldest expected one.
  always @(negedge clk) begin
    if (reset_L && data_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got data_out=%0h expected no valid", data_out);
      end else begin
        chk("pop_data", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input logic p, input int d, input logic q, input logic c);
    logic [31:0] dv;
    dv      = d;
    push    = p;
    data_in = dv[DW-1:0];
    pop     = q;
    err_clr = c;
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic pop_exp(input int v);
    exp_q.push_back(v);
    step(1'b0, 0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_L    = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    err_clr    = 1'b0;
    data_in    = '0;
    afull_thr  = 3'd3;
    aempty_thr = 3'd1;
    #22;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_aempty", 32'(almost_empty), 0);
    chk("rst_pause", 32'(pause), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_dvalid", 32'(data_valid), 0);
    chk("rst_dout", 32'(data_out), 0);
    reset_L = 1'b1;

    // Fill to full, then overflow.
    step(1'b1, 'h01, 1'b0, 1'b0);
    chk("fill1_aempty", 32'(almost_empty), 1);
    step(1'b1, 'h02, 1'b0, 1'b0);
    step(1'b1, 'h03, 1'b0, 1'b0);
    chk("fill3_pause", 32'(pause), 1);
    step(1'b1, 'h04, 1'b0, 1'b0);
    chk("fill4_count", 32'(count), 4);
    chk("fill4_full", 32'(full), 1);
    chk("fill4_afull", 32'(almost_full), 1);
    chk("fill4_empty", 32'(empty), 0);
    step(1'b1, 'h05, 1'b0, 1'b0);
    chk("ovf_error", 32'(error), 1);
    chk("ovf_count", 32'(count), 4);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("clr_error", 32'(error), 0);

    // Drain; 0x04 must be intact despite the rejected 0x05.
    pop_exp('h01);
    pop_exp('h02);
    pop_exp('h03);
    pop_exp('h04);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_pause", 32'(pause), 0);
    step(1'b0, 0, 1'b1, 1'b0);
    chk("udf_error", 32'(error), 1);
    chk("udf_dvalid", 32'(data_valid), 0);
    chk("udf_dout", 32'(data_out), 'h04);
    step(1'b0, 0, 1'b0, 1'b1);

    // Pause hysteresis between thresholds 3 and 1.
    step(1'b1, 'h10, 1'b0, 1'b0);
    step(1'b1, 'h11, 1'b0, 1'b0);
    chk("hys_c2_pause", 32'(pause), 0);
    step(1'b1, 'h12, 1'b0, 1'b0);
    chk("hys_c3_pause", 32'(pause), 1);
    pop_exp('h10);
    chk("hys_down2_pause", 32'(pause), 1);
    pop_exp('h11);
    chk("hys_down1_pause", 32'(pause), 0);
    step(1'b1, 'h13, 1'b0, 1'b0);
    chk("hys_up2_pause", 32'(pause), 0);
    chk("hys_up2_count", 32'(count), 2);

    // Simultaneous push and pop on a full FIFO.
    step(1'b1, 'h14, 1'b0, 1'b0);
    step(1'b1, 'h15, 1'b0, 1'b0);
    chk("pp_pre_full", 32'(full), 1);
    exp_q.push_back('h12);
    step(1'b1, 'h2A, 1'b1, 1'b0);
    chk("pp_count", 32'(count), 4);
    chk("pp_dvalid", 32'(data_valid), 1);
    chk("pp_error", 32'(error), 0);
    pop_exp('h13);
    pop_exp('h14);
    pop_exp('h15);
    pop_exp('h2A);
    chk("pp_drain_empty", 32'(empty), 1);

    // Alternating push/pop wraps both pointers several times.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, i, 1'b0, 1'b0);
      chk("wrap_count_push", 32'(count), 1);
      pop_exp(i);
      chk("wrap_count_pop", 32'(count), 0);
    end

    // Asynchronous reset in the middle of traffic.
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b1, 'h20, 1'b0, 1'b0);
    step(1'b1, 'h21, 1'b0, 1'b0);
    step(1'b1, 'h22, 1'b0, 1'b0);
    chk("mid_pre_count", 32'(count), 3);
    chk("mid_pre_error", 32'(error), 1);
    afull_thr = 3'd4;
    #1;
    chk("thr_live_afull_off", 32'(almost_full), 0);
    afull_thr = 3'd3;
    #1;
    chk("thr_live_afull_on", 32'(almost_full), 1);
    reset_L = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_pause", 32'(pause), 0);
    chk("mid_rst_error", 32'(error), 0);
    @(posedge clk);
    #3;
    reset_L = 1'b1;
    step(1'b0, 0, 1'b1, 1'b0);
    chk("post_rst_udf_error", 32'(error), 1);
    chk("post_rst_dvalid", 32'(data_valid), 0);
    chk("post_rst_count", 32'(count), 0);
    step(1'b0, 0, 1'b0, 1'b1);

    // err_clr loses to a simultaneous overflow.
    step(1'b1, 'h30, 1'b0, 1'b0);
    step(1'b1, 'h31, 1'b0, 1'b0);
    step(1'b1, 'h32, 1'b0, 1'b0);
    step(1'b1, 'h33, 1'b0, 1'b0);
    step(1'b1, 'h34, 1'b0, 1'b1);
    chk("clr_ovf_error", 32'(error), 1);
    chk("clr_ovf_count", 32'(count), 4);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("clr_alone_error", 32'(error), 0);
    pop_exp('h30);
    pop_exp('h31);
    pop_exp('h32);
    pop_exp('h33);

    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_flow_ctrl.md
Name: fifo_flow_ctrl

Overview:
- Parametrised synchronous FIFO with programmable almost-full/almost-empty thresholds.
- Pause output with hysteresis, sticky error, and registered pop data with a valid strobe.
- Sits between a packet source and a downstream arbiter/demux. Pause throttles the upstream pusher.
- Next-generation buffer for the datapath: data width, depth and threshold width are all generalised.

Parameters:
DATA_WIDTH, 6, bits per entry
ADDR_WIDTH, 2, pointer width; DEPTH = 2**ADDR_WIDTH entries
CNT_WIDTH, ADDR_WIDTH+1, occupancy/threshold width (derived; do not override)

Ports:
clk  in  1  single clock, all state on rising edge
reset_L  in  1  asynchronous, active-low reset
push  in  1  write request
data_in  in  DATA_WIDTH  write data
pop  in  1  read request
afull_thr  in  CNT_WIDTH  almost-full / pause-assert threshold
aempty_thr  in  CNT_WIDTH  almost-empty / pause-release threshold
err_clr  in  1  clears sticky error
data_out  out  DATA_WIDTH  registered read data
data_valid  out  1  data_out holds a newly popped word this cycle
count  out  CNT_WIDTH  current occupancy, 0..DEPTH
empty  out  1  count==0
full  out  1  count==DEPTH
almost_full  out  1  count>=afull_thr
almost_empty  out  1  count<=aempty_thr and count!=0
pause  out  1  hysteretic backpressure to upstream
error  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk release):
  - count=0, wr_ptr=rd_ptr=0, data_out=0, data_valid=0, pause=0, error=0.
  - empty=1; full, almost_full, almost_empty=0.
  - Memory contents are not reset.
  - Asserting reset mid-operation discards all entries immediately.
- Accept rules, evaluated on the current count:
  - push_ok = push & (!full | pop).
  - pop_ok = pop & !empty.
  - A push when full with pop=1 is accepted, because the pop frees a slot in the same edge.
- Write: on push_ok, mem[wr_ptr]<=data_in and wr_ptr increments. Wrap is natural modulo DEPTH.
- Read:
  - On pop_ok, data_out<=mem[rd_ptr], rd_ptr increments, and data_valid=1 for exactly the next cycle.
  - Otherwise data_valid=0 and data_out holds its value.
  - Read latency is 1 cycle.
- No bypass: push and pop together when empty gives pop rejected (underflow) and push accepted, so count becomes 1.
- count next value:
  - +1 if push_ok & !pop_ok.
  - -1 if pop_ok & !push_ok.
  - Unchanged otherwise.
- empty, full, almost_full, almost_empty: combinational decode of the registered count only. They are never a function of push/pop.
- pause (registered, evaluated on next-count):
  - Set when next_count>=afull_thr.
  - Cleared when next_count<=aempty_thr.
  - Otherwise holds.
  - If both conditions are true (misprogrammed thresholds), set wins.
  - afull_thr=0 means pause is permanently 1 after the first clock.
- error (registered, sticky):
  - Set on overflow (push & full & !pop) or underflow (pop & empty).
  - Cleared by err_clr.
  - A new error event in the same cycle as err_clr leaves error=1.
  - A rejected operation changes no pointer, count or data_out.
- Thresholds may change at any time; flags reflect new values combinationally, pause on the next edge.

Decomposition:
- Shared package holds:
  - Constants: default DATA_WIDTH, ADDR_WIDTH.
  - Function computing CNT_WIDTH.
  - Localparams for the error cause encoding (overflow, underflow), reused by the debug status register.
- One sub-module: fifo_flow_mem, a DEPTH x DATA_WIDTH register array with write port and registered read port.
  - It has no reset on the array; its registered read output is reset to 0.
- Pointer/count/flag logic stays in the top.

Test Plan:
- Default params: push 0x01,0x02,0x03,0x04 on 4 cycles.
  - count=4, full=1, almost_full=1 with afull_thr=3.
  - A 5th push sets error=1, count stays 4, and 0x04 is not overwritten.
- Pop 4 times from full.
  - data_out 0x01..0x04, each with data_valid=1 one cycle after its pop.
  - Afterwards empty=1.
  - An extra pop sets error=1, data_out stays 0x04, data_valid=0.
- afull_thr=3, aempty_thr=1: push to 3, pause=1.
  - Pop to 2: pause stays 1.
  - Pop to 1: pause=0.
  - Push to 2: pause stays 0.
- Full FIFO, push=pop=1 with data 0x2A: count stays 4, data_valid=1, error=0. After the pops drain, 0x2A emerges last.
- Wrap: 10 cycles of alternating push/pop with values 0..9.
  - Outputs match in order and count never exceeds 1.
  - Pointers wrap past 3 correctly.
- Reset mid-operation: with count=3, drop reset_L between edges.
  - Immediately count=0, empty=1, pause=0, error=0.
  - After release, the first pop flags underflow.
- err_clr: a cycle with err_clr and overflow together keeps error=1; err_clr alone next cycle clears it to 0.
